instr_encode_loader: RTL and testbench

Sequential writer that mirrors instr_decode. It accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit CSE-BUBBLE instruction words. Packed words are buffered in a small FIFO and written one per cycle into instruction memory from a programmable base address. It is used by the boot/test loader to fill imem before the core leaves reset.

---
 rtl/isa_pkg.sv | 68 ++++++
 rtl/sync_fifo.sv | 41 ++++
 rtl/instr_encode_loader.sv | 109 ++++++++++
 tb/tb_instr_encode_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// CSE-BUBBLE instruction-format constants, FSM state type and field encoder
// shared by the instruction loader.
package isa_pkg;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_RSV = 2'b11;

    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic [1:0]         fmt;
        logic [OP_W-1:0]    opcode;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   shamt;
        logic [FUNCT_W-1:0] funct;
        logic [IMM_W-1:0]   imm;
        logic [TGT_W-1:0]   target;
    } fields_t;

    // Reserved format encodes to an all-zero word.
    function automatic logic [31:0] encode(input fields_t f);
        logic [31:0] w;
        w = '0;
        case (f.fmt)
            FMT_R: begin
                w[OP_LSB +: OP_W]       = f.opcode;
                w[RS_LSB +: REG_W]      = f.rs;
                w[RT_LSB +: REG_W]      = f.rt;
                w[RD_LSB +: REG_W]      = f.rd;
                w[SHAMT_LSB +: REG_W]   = f.shamt;
                w[0 +: FUNCT_W]         = f.funct;
            end
            FMT_I: begin
                w[OP_LSB +: OP_W]  = f.opcode;
                w[RS_LSB +: REG_W] = f.rs;
                w[RT_LSB +: REG_W] = f.rt;
                w[0 +: IMM_W]      = f.imm;
            end
            FMT_J: begin
                w[OP_LSB +: OP_W] = f.opcode;
                w[0 +: TGT_W]     = f.target;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers for full/empty; show-ahead read.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Packs decoded instruction fields into CSE-BUBBLE words and streams them into imem.
// Define ENCODE_RANGE_CHECK_EN to flag R/J bundles whose opcode does not fit the format.
module instr_encode_loader
    import isa_pkg::*;
#(
    parameter int IMEM_AW    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IMEM_AW-1:0] base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_fmt,
    input  logic [5:0]         in_opcode,
    input  logic [4:0]         in_rs,
    input  logic [4:0]         in_rt,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_shamt,
    input  logic [5:0]         in_funct,
    input  logic [15:0]        in_imm,
    input  logic [25:0]        in_target,
    input  logic               in_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    input  logic               imem_ready,
    output logic               busy,
    output logic               done,
    output logic [IMEM_AW:0]   count,
    output logic               err
);
    state_t             state, state_nx;
    fields_t            fields;
    logic [31:0]        word, head;
    logic [IMEM_AW-1:0] base;
    logic [IMEM_AW:0]   push_cnt;
    logic               fifo_full, fifo_empty;
    logic               push, pop, overflow, bad_field;

    assign fields = '{fmt: in_fmt, opcode: in_opcode, rs: in_rs, rt: in_rt, rd: in_rd,
                      shamt: in_shamt, funct: in_funct, imm: in_imm, target: in_target};
    assign word = encode(fields);

    // The push counter never exceeds 2^IMEM_AW, so its top bit is the overflow flag.
    assign overflow   = push_cnt[IMEM_AW];
    assign busy       = (state == ST_LOAD) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign in_ready   = (state == ST_LOAD) && !fifo_full && !overflow;
    assign imem_we    = busy && !fifo_empty;
    assign imem_wdata = imem_we ? head : '0;
    assign imem_addr  = base + count[IMEM_AW-1:0];
    assign push       = in_valid && in_ready;
    assign pop        = imem_we && imem_ready;

    always_comb begin
        bad_field = (in_fmt == FMT_RSV);
`ifdef ENCODE_RANGE_CHECK_EN
        if (in_fmt == FMT_R && in_opcode != OP_RTYPE) bad_field = 1'b1;
        if (in_fmt == FMT_J && in_opcode != OP_J && in_opcode != OP_JAL) bad_field = 1'b1;
`endif
    end

    sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_LOAD;
            ST_LOAD:  if ((push && in_last) || overflow) state_nx = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            base     <= '0;
            count    <= '0;
            push_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                base     <= base_addr;
                count    <= '0;
                push_cnt <= '0;
                err      <= 1'b0;
            end else begin
                if (pop)  count    <= count + 1'b1;
                if (push) push_cnt <= push_cnt + 1'b1;
                if ((push && bad_field) || (state == ST_LOAD && overflow)) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: default instance plus a 2-bit-address
// instance for the word-limit overflow and address wrap cases.
module tb_instr_encode_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [1:0]  base2 = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, imem_ready = 1'b1;
    logic [1:0]  in_fmt = '0;
    logic [5:0]  in_opcode = '0, in_funct = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;

    logic        in_ready, imem_we, busy, done, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;
    logic        in_ready2, imem_we2, busy2, done2, err2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  count2;

    int n_cmp = 0, n_bad = 0, done_cnt = 0, done2_cnt = 0;
    logic [39:0] wq[$];
    logic [33:0] wq2[$];
    bit acc;

    always #5 clk = ~clk;

    instr_encode_loader #(.IMEM_AW(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready), .busy(busy), .done(done), .count(count), .err(err));

    instr_encode_loader #(.IMEM_AW(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base2),
        .in_valid(in_valid), .in_ready(in_ready2), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .imem_ready(imem_ready), .busy(busy2), .done(done2), .count(count2), .err(err2));

    // Inputs change just after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (imem_we && imem_ready) wq.push_back({imem_addr, imem_wdata});
        if (imem_we2 && imem_ready) wq2.push_back({imem_addr2, imem_wdata2});
        if (done) done_cnt++;
        if (done2) done2_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input int sel, input logic [1:0] f, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last, input int max,
                        output bit ok);
        in_fmt = f; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            if ((sel == 0) ? in_ready : in_ready2) ok = 1'b1;
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin step(); n++; end
        chk(tag, busy, 1'b0);
        step();
    endtask

    task automatic go(input logic [7:0] b);
        base_addr = b; start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        @(negedge clk); rst = 1'b0; step();

        // Single I-type word
        go(8'h10);
        chk("i_ready", in_ready, 1);
        send(0, 2'b01, 6'b000001, 5'd15, 5'd15, 0, 0, 0, 16'hFFFF, 0, 1, 10, acc);
        chk("i_acc", acc, 1);
        chk("i_lat_we", imem_we, 1);
        chk("i_lat_wdata", imem_wdata, 32'h05EFFFFF);
        chk("i_lat_addr", imem_addr, 8'h10);
        wait_idle("i_idle");
        chk("i_nwr", wq.size(), 1);
        chk("i_wr0", wq[0], {8'h10, 32'h05EFFFFF});
        chk("i_count", count, 1);
        chk("i_done", done_cnt, 1);
        chk("i_err", err, 0);

        // R-type then J-type
        wq.delete(); go(8'h20);
        send(0, 2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 0, 0, 0, 10, acc);
        chk("rj_acc0", acc, 1);
        send(0, 2'b10, 6'b000010, 0, 0, 0, 0, 0, 0, 26'h100, 1, 10, acc);
        chk("rj_acc1", acc, 1);
        wait_idle("rj_idle");
        chk("rj_nwr", wq.size(), 2);
        chk("rj_wr0", wq[0], {8'h20, 32'h00221820});
        chk("rj_wr1", wq[1], {8'h21, 32'h08000100});
        chk("rj_count", count, 2);
        chk("rj_done", done_cnt, 2);

        // Backpressure: FIFO fills after 4, outputs hold while stalled
        wq.delete(); imem_ready = 1'b0; go(8'h40);
        for (int i = 0; i < 4; i++) begin
            send(0, 2'b01, 6'b000001, 0, 0, 0, 0, 0, 16'(i), 0, 0, 10, acc);
            chk("bp_acc", acc, 1);
        end
        chk("bp_full_ready", in_ready, 0);
        chk("bp_we", imem_we, 1);
        chk("bp_addr", imem_addr, 8'h40);
        chk("bp_wdata", imem_wdata, 32'h04000000);
        repeat (6) step();
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_we", imem_we, 1);
        chk("bp_hold_addr", imem_addr, 8'h40);
        chk("bp_hold_wdata", imem_wdata, 32'h04000000);
        chk("bp_hold_count", count, 0);
        imem_ready = 1'b1;
        send(0, 2'b01, 6'b000001, 0, 0, 0, 0, 0, 16'd4, 0, 0, 10, acc);
        chk("bp_acc4", acc, 1);
        send(0, 2'b01, 6'b000001, 0, 0, 0, 0, 0, 16'd5, 0, 1, 10, acc);
        chk("bp_acc5", acc, 1);
        wait_idle("bp_idle");
        chk("bp_nwr", wq.size(), 6);
        for (int i = 0; i < 6 && i < wq.size(); i++)
            chk("bp_wr", wq[i], {8'(8'h40 + i), 32'(32'h04000000 + i)});
        chk("bp_count", count, 6);

        // Reserved format: zero word, sticky err
        wq.delete(); go(8'h80);
        send(0, 2'b11, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1, 10, acc);
        chk("rsv_acc", acc, 1);
        wait_idle("rsv_idle");
        chk("rsv_wr", wq.size() == 1 ? wq[0] : 40'hX, {8'h80, 32'h0});
        repeat (3) step();
        chk("rsv_err_sticky", err, 1);

        // Reset during DRAIN with two words queued
        wq.delete(); imem_ready = 1'b0; go(8'h00);
        chk("rd_err_clr", err, 0);
        send(0, 2'b01, 6'b000001, 0, 0, 0, 0, 0, 16'd1, 0, 0, 10, acc);
        send(0, 2'b01, 6'b000001, 0, 0, 0, 0, 0, 16'd2, 0, 1, 10, acc);
        chk("rd_busy", busy, 1);
        chk("rd_we_pre", imem_we, 1);
        rst = 1'b1; #1;
        chk("rd_we", imem_we, 0);
        chk("rd_count", count, 0);
        chk("rd_busy_rst", busy, 0);
        repeat (2) step();
        rst = 1'b0; imem_ready = 1'b1;
        repeat (5) step();
        chk("rd_nwr", wq.size(), 0);
        chk("rd_we_post", imem_we, 0);
        chk("rd_idle_busy", busy, 0);

        // Overflow with 2-bit addresses: 4 writes wrapping 3,0,1,2
        base2 = 2'b11; start2 = 1'b1; step(); start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1, 2'b01, 6'b000001, 0, 0, 0, 0, 0, 16'(i), 0, 0, 10, acc);
            chk("ov_acc", acc, 1);
        end
        send(1, 2'b01, 6'b000001, 0, 0, 0, 0, 0, 16'd4, 0, 0, 10, acc);
        chk("ov_rej5", acc, 0);
        repeat (3) step();
        chk("ov_busy", busy2, 0);
        chk("ov_nwr", wq2.size(), 4);
        for (int i = 0; i < 4 && i < wq2.size(); i++)
            chk("ov_wr", wq2[i], {2'(3 + i), 32'(32'h04000000 + i)});
        chk("ov_err", err2, 1);
        chk("ov_count", count2, 3'd4);
        chk("ov_done", done2_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
